uart_tx_path: RTL and testbench
===============================

Name: uart_tx_path

Overview:
- Transmit half of the UART core, directly downstream of the APB UART slave interface.
- Accepts 1-cycle byte push pulses, buffers them in a TX FIFO, and serialises each byte onto the `tx` pin as 8N1 frames, LSB first.
- Reports FIFO-full back upstream; the APB status register bit[1] reads `o_tx_full`.

Parameters:
- CLK_FREQ, 100_000_000, clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. BIT_CYCLES = CLK_FREQ / BAUD (integer truncation); must be >= 2.
- FIFO_DEPTH, 4, number of TX FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_tx_pushdata  input  8  byte to enqueue.
- i_tx_push  input  1  1-cycle enqueue strobe.
- o_tx_full  output  1  FIFO holds FIFO_DEPTH entries.
- o_tx_empty  output  1  FIFO holds 0 entries.
- o_tx_busy  output  1  a frame is on the line (FSM not IDLE).
- tx  output  1  serial line; idle high.

Behaviour:
- Clock/reset: one clock (`clk`). Reset `rst_n` is asynchronous, active-low.
- Reset values:
  - tx=1, o_tx_full=0, o_tx_empty=1, o_tx_busy=0.
  - FIFO pointers and count=0; FSM=IDLE; baud counter=0; bit index=0.
- Mid-frame reset: tx forced to 1 immediately (asynchronous). Queued data is discarded.
- FIFO:
  - Registered circular buffer. Read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
  - o_tx_full and o_tx_empty are decoded from the registered count.
  - A push is accepted iff i_tx_push=1 and o_tx_full=0.
  - A push while full is dropped, even if a pop occurs in the same cycle. Dropped data and pointers are unchanged.
  - Simultaneous accepted push and pop: count unchanged, both pointers advance.
  - A push is visible to the FSM (o_tx_empty=0) the cycle after the strobe.
- FSM: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If o_tx_empty=0: pop the head into an 8-bit shift register, go to START, clear the baud counter.
  - START: tx=0 for BIT_CYCLES clocks, then go to DATA with bit index=0.
  - DATA: tx=shift[0] for BIT_CYCLES clocks per bit, shifting right after each bit. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for BIT_CYCLES clocks. At the last STOP cycle:
    - If the FIFO is non-empty: pop and go directly to START (back-to-back, zero idle cycles).
    - Otherwise: go to IDLE.
- tx is driven from a register (glitch-free). It changes only on state/bit boundaries.
- Baud counter: counts 0..BIT_CYCLES-1 within each bit. A bit ends when the count equals BIT_CYCLES-1. The counter resets to 0 at every bit boundary.
- Frame length: exactly 10*BIT_CYCLES clocks.
- Latency: strobe in cycle N → FIFO write at edge N+1 → FSM pop at edge N+2 → tx=0 from N+2 (two cycles strobe-to-start-bit when idle).
- o_tx_busy=1 in START/DATA/STOP. It remains 1 across back-to-back frames.
- i_tx_push while busy is enqueued normally. Frame in progress is unaffected.

Test Plan (CLK_FREQ=100_000_000, BAUD=10_000_000 → BIT_CYCLES=10):
- Reset release, no push → tx=1, o_tx_empty=1, o_tx_full=0, o_tx_busy=0 for 100 cycles.
- Single push 8'hA5 at cycle N → tx low from N+2 for 10 clk; then bits 1,0,1,0,0,1,0,1 (LSB first) at 10 clk each; stop high 10 clk; o_tx_busy=0 after 100 clk; o_tx_empty=1.
- Push 8'h55, 8'h0F, 8'hF0 on consecutive cycles → three frames back-to-back, each exactly 100 clk with no idle gap; decoded bytes 55, 0F, F0 in order.
- FSM mid-frame on byte 0, push 5 more bytes (FIFO_DEPTH=4) → o_tx_full=1 after 4th accepted push; 5th byte dropped; exactly 5 frames total transmitted, the dropped byte never appears.
- Push while full in the same cycle as the STOP→START pop → push dropped, count goes 4→3, o_tx_full deasserts next cycle.
- Assert rst_n=0 during DATA bit 3 of byte 8'h3C with 2 bytes queued → tx=1 immediately; after release o_tx_empty=1, o_tx_busy=0, no further frames.

Source files
------------

// File: rtl/uart_tx_path.sv
// UART transmit path: byte FIFO feeding an 8N1 serialiser.
// Bytes go out LSB first on a registered, idle-high tx line.
module uart_tx_path #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_tx_pushdata,
  input  logic       i_tx_push,
  output logic       o_tx_full,
  output logic       o_tx_empty,
  output logic       o_tx_busy,
  output logic       tx
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int CW = $clog2(BIT_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic push_ok;
  logic pop;
  logic bit_end;

  assign o_tx_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign o_tx_empty = (count == '0);
  assign o_tx_busy  = (state != IDLE);

  assign push_ok = i_tx_push && !o_tx_full;
  assign bit_end = (baud_cnt == CW'(BIT_CYCLES - 1));

  // The FSM takes the head either from IDLE or on the last stop cycle.
  assign pop = !o_tx_empty &&
               ((state == IDLE) ||
                (state == STOP && bit_end));

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= i_tx_pushdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop) begin
        count <= count + 1'b1;
      end else if (!push_ok && pop) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_path.sv
// Bench for uart_tx_path: a line monitor decodes frames
// and each scenario checks them against an expected-byte queue.
module tb_uart_tx_path;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push = 1'b0;
  logic [7:0] pdata = 8'h00;
  logic       full;
  logic       empty;
  logic       busy;
  logic       tx;

  uart_tx_path #(
    .CLK_FREQ  (100_000_000),
    .BAUD      (10_000_000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_tx_pushdata(pdata),
    .i_tx_push    (push),
    .o_tx_full    (full),
    .o_tx_empty   (empty),
    .o_tx_busy    (busy),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] b;
    int         start;
    bit         ok;
    logic       busy_last;
  } rx_t;

  rx_t        rx_q[$];
  logic [7:0] exp_q[$];

  // Frame decoder: 100 samples per frame, one per clock.
  initial begin : mon
    logic s [100];
    bit   ab;
    rx_t  r;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        r.start = cyc;
        s[0] = 1'b0;
        ab = 1'b0;
        r.busy_last = 1'b0;
        for (int t = 1; t < 100; t++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            ab = 1'b1;
            break;
          end
          s[t] = tx;
          if (t == 99) r.busy_last = busy;
        end
        if (!ab) begin
          r.ok = 1'b1;
          for (int j = 0; j < 10; j++)
            for (int k = 1; k < 10; k++)
              if (s[j*10+k] !== s[j*10]) r.ok = 1'b0;
          if (s[90] !== 1'b1) r.ok = 1'b0;
          for (int j = 0; j < 8; j++) r.b[j] = s[10+10*j];
          rx_q.push_back(r);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic push_byte(input logic [7:0] d, output int c);
    @(posedge clk);
    #1;
    c = cyc;
    pdata = d;
    push = 1'b1;
    @(posedge clk);
    #1;
    push = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit to);
    int i;
    i = 0;
    while (rx_q.size() < n && i < budget) begin
      @(posedge clk);
      i++;
    end
    to = (rx_q.size() < n);
  endtask

  task automatic wait_cyc(input int target, output bit to);
    int i;
    i = 0;
    while (cyc != target && i < 2000) begin
      @(posedge clk);
      #1;
      i++;
    end
    to = (cyc != target);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({tx, full, empty, busy} !== 4'b1010) begin
      fails++;
      $display("FAIL reset_vals: got %b want 1010",
               {tx, full, empty, busy});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      tests++;
      if ({tx, full, empty, busy} !== 4'b1010) begin
        fails++;
        $display("FAIL idle_after_reset cyc %0d: got %b want 1010",
                 i, {tx, full, empty, busy});
      end
    end
  endtask

  task automatic test_single;
    int  c0;
    bit  to;
    rx_t r;
    logic [7:0] e;
    push_byte(8'hA5, c0);
    exp_q.push_back(8'hA5);
    wait_rx(1, 300, to);
    tests++;
    if (to) begin
      fails++;
      $display("FAIL single_timeout: got 0 frames want 1");
    end else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      tests++;
      if (r.b !== e) begin
        fails++;
        $display("FAIL single_byte: got %h want %h", r.b, e);
      end
      tests++;
      if (!r.ok) begin
        fails++;
        $display("FAIL single_shape: got 0 want 1");
      end
      tests++;
      if (r.start !== c0 + 2) begin
        fails++;
        $display("FAIL single_latency: got %0d want %0d",
                 r.start - c0, 2);
      end
      tests++;
      if (r.busy_last !== 1'b1) begin
        fails++;
        $display("FAIL single_busy_stop: got %b want 1",
                 r.busy_last);
      end
      @(negedge clk);
      tests++;
      if ({busy, empty, tx} !== 3'b011) begin
        fails++;
        $display("FAIL single_end: got busy/empty/tx %b want 011",
                 {busy, empty, tx});
      end
    end
  endtask

  task automatic test_back_to_back;
    int  c0;
    bit  to;
    rx_t r [3];
    logic [7:0] d [3];
    logic [7:0] e;
    d[0] = 8'h55;
    d[1] = 8'h0F;
    d[2] = 8'hF0;
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      pdata = d[i];
      push = 1'b1;
      exp_q.push_back(d[i]);
      @(posedge clk);
      #1;
    end
    push = 1'b0;
    wait_rx(3, 500, to);
    tests++;
    if (to) begin
      fails++;
      $display("FAIL b2b_timeout: got %0d frames want 3",
               rx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        r[i] = rx_q.pop_front();
        e = exp_q.pop_front();
        tests++;
        if (r[i].b !== e || !r[i].ok) begin
          fails++;
          $display("FAIL b2b_byte%0d: got %h ok=%b want %h ok=1",
                   i, r[i].b, r[i].ok, e);
        end
      end
      tests++;
      if (r[0].start !== c0 + 2) begin
        fails++;
        $display("FAIL b2b_latency: got %0d want 2",
                 r[0].start - c0);
      end
      for (int i = 1; i < 3; i++) begin
        tests++;
        if (r[i].start - r[i-1].start !== 100) begin
          fails++;
          $display("FAIL b2b_gap%0d: got %0d want 100",
                   i, r[i].start - r[i-1].start);
        end
      end
      @(negedge clk);
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL b2b_idle: got busy %b want 0", busy);
      end
    end
  endtask

  task automatic test_full_drop;
    int  c0;
    bit  to;
    rx_t r;
    logic [7:0] e;
    push_byte(8'h11, c0);
    exp_q.push_back(8'h11);
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if ({busy, empty} !== 2'b11) begin
      fails++;
      $display("FAIL drop_midframe: got busy/empty %b want 11",
               {busy, empty});
    end
    for (int i = 0; i < 5; i++) begin
      pdata = 8'h21 + 8'(i);
      push = 1'b1;
      if (i < 4) exp_q.push_back(8'h21 + 8'(i));
      if (i == 4) begin
        tests++;
        if (full !== 1'b1) begin
          fails++;
          $display("FAIL drop_full: got %b want 1", full);
        end
      end
      @(posedge clk);
      #1;
    end
    push = 1'b0;
    tests++;
    if (full !== 1'b1) begin
      fails++;
      $display("FAIL drop_still_full: got %b want 1", full);
    end
    wait_rx(5, 800, to);
    tests++;
    if (to) begin
      fails++;
      $display("FAIL drop_timeout: got %0d frames want 5",
               rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        r = rx_q.pop_front();
        e = exp_q.pop_front();
        tests++;
        if (r.b !== e || !r.ok) begin
          fails++;
          $display("FAIL drop_byte%0d: got %h ok=%b want %h ok=1",
                   i, r.b, r.ok, e);
        end
      end
    end
    repeat (150) @(posedge clk);
    @(negedge clk);
    tests++;
    if (rx_q.size() != 0 || busy !== 1'b0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL drop_extra: got %0d extra busy=%b empty=%b want 0 0 1",
               rx_q.size(), busy, empty);
    end
    rx_q.delete();
  endtask

  task automatic test_push_at_pop;
    int  c0;
    int  s0;
    bit  to;
    rx_t r;
    rx_t r0;
    logic [7:0] e;
    push_byte(8'h30, c0);
    exp_q.push_back(8'h30);
    s0 = c0 + 2;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      pdata = 8'h31 + 8'(i);
      push = 1'b1;
      exp_q.push_back(8'h31 + 8'(i));
      @(posedge clk);
      #1;
    end
    push = 1'b0;
    wait_cyc(s0 + 99, to);
    tests++;
    if (to) begin
      fails++;
      $display("FAIL pop_sync: got cyc %0d want %0d", cyc, s0 + 99);
    end
    pdata = 8'hEE;
    push = 1'b1;
    tests++;
    if ({full, busy} !== 2'b11) begin
      fails++;
      $display("FAIL pop_pre: got full/busy %b want 11",
               {full, busy});
    end
    @(posedge clk);
    #1;
    push = 1'b0;
    tests++;
    if ({full, empty, busy} !== 3'b001) begin
      fails++;
      $display("FAIL pop_post: got full/empty/busy %b want 001",
               {full, empty, busy});
    end
    wait_rx(5, 700, to);
    tests++;
    if (to) begin
      fails++;
      $display("FAIL pop_timeout: got %0d frames want 5",
               rx_q.size());
    end else begin
      r0 = rx_q[0];
      tests++;
      if (rx_q[1].start - r0.start !== 100) begin
        fails++;
        $display("FAIL pop_gap: got %0d want 100",
                 rx_q[1].start - r0.start);
      end
      for (int i = 0; i < 5; i++) begin
        r = rx_q.pop_front();
        e = exp_q.pop_front();
        tests++;
        if (r.b !== e || !r.ok) begin
          fails++;
          $display("FAIL pop_byte%0d: got %h ok=%b want %h ok=1",
                   i, r.b, r.ok, e);
        end
      end
    end
    repeat (150) @(posedge clk);
    tests++;
    if (rx_q.size() != 0) begin
      fails++;
      $display("FAIL pop_extra: got %0d frames want 0", rx_q.size());
    end
    rx_q.delete();
  endtask

  task automatic test_mid_reset;
    int c0;
    int s0;
    bit to;
    push_byte(8'h3C, c0);
    s0 = c0 + 2;
    for (int i = 0; i < 2; i++) begin
      pdata = 8'hA1 + 8'(i);
      push = 1'b1;
      @(posedge clk);
      #1;
    end
    push = 1'b0;
    wait_cyc(s0 + 45, to);
    tests++;
    if (to || {busy, empty, tx} !== 3'b101) begin
      fails++;
      $display("FAIL rst_pre: got busy/empty/tx %b want 101",
               {busy, empty, tx});
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({tx, full, empty, busy} !== 4'b1010) begin
      fails++;
      $display("FAIL rst_async: got %b want 1010",
               {tx, full, empty, busy});
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    repeat (200) @(posedge clk);
    @(negedge clk);
    tests++;
    if (rx_q.size() != 0 || {tx, empty, busy} !== 3'b110) begin
      fails++;
      $display("FAIL rst_after: got %0d frames tx/empty/busy %b want 0 110",
               rx_q.size(), {tx, empty, busy});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_drop();
    test_push_at_pop();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
